uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional macro UART_ARB_TAG_EN: send a source-tag byte before data when the source changes.
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 2,
  parameter int          PAYLOAD_BITS = 8,
  parameter int          GAP_CYCLES   = 0,
  parameter logic [7:0]  TAG_BASE     = 8'h30,
  localparam int         ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_en,
  output logic [PAYLOAD_BITS-1:0]         tx_data,
  input  logic                            tx_busy,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            active
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP
`ifdef UART_ARB_TAG_EN
    , TAG_ISSUE
`endif
  } state_t;

  state_t            state, after_frame;
  logic [ID_W-1:0]   rr_ptr, winner, rr_next;
  logic              any_valid;
  logic [15:0]       gap_cnt;
  logic              wb_cnt;
  logic [PAYLOAD_BITS-1:0] win_data;

`ifdef UART_ARB_TAG_EN
  logic [PAYLOAD_BITS-1:0] hold_data, tag_byte;
  logic [ID_W-1:0]         last_src;
  logic                    last_src_valid, tag_phase;

  assign tag_byte    = PAYLOAD_BITS'(32'(TAG_BASE) + 32'(winner));
  assign after_frame = tag_phase ? ISSUE : IDLE;
`else
  assign after_frame = IDLE;
`endif

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign rr_next  = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  assign win_data = req_data[int'(winner)*PAYLOAD_BITS +: PAYLOAD_BITS];

  always_comb begin
    req_ready = '0;
    if (resetn && state == IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  always_comb begin
    tx_en = 1'b0;
    if (state == ISSUE) tx_en = !tx_busy;
`ifdef UART_ARB_TAG_EN
    if (state == TAG_ISSUE) tx_en = !tx_busy;
`endif
  end

  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      wb_cnt   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      hold_data      <= '0;
      last_src       <= '0;
      last_src_valid <= 1'b0;
      tag_phase      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant_id <= winner;
          rr_ptr   <= rr_next;
`ifdef UART_ARB_TAG_EN
          if (!last_src_valid || last_src != winner) begin
            tx_data   <= tag_byte;
            hold_data <= win_data;
            tag_phase <= 1'b1;
            state     <= TAG_ISSUE;
          end else begin
            tx_data <= win_data;
            state   <= ISSUE;
          end
`else
          tx_data <= win_data;
          state   <= ISSUE;
`endif
        end
        ISSUE: if (!tx_busy) begin
          state  <= WAIT_BUSY;
          wb_cnt <= 1'b0;
`ifdef UART_ARB_TAG_EN
          last_src       <= grant_id;
          last_src_valid <= 1'b1;
          tag_phase      <= 1'b0;
`endif
        end
`ifdef UART_ARB_TAG_EN
        TAG_ISSUE: if (!tx_busy) begin
          state  <= WAIT_BUSY;
          wb_cnt <= 1'b0;
        end
`endif
        // Two-cycle timeout covers a busy pulse the transmitter never raised.
        WAIT_BUSY: begin
          if (tx_busy || wb_cnt) state <= WAIT_DONE;
          else                   wb_cnt <= 1'b1;
        end
        WAIT_DONE: if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            state <= after_frame;
`ifdef UART_ARB_TAG_EN
            if (tag_phase) tx_data <= hold_data;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= after_frame;
`ifdef UART_ARB_TAG_EN
            if (tag_phase) tx_data <= hold_data;
`endif
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (GAP 0 and GAP 4) driven in parallel, each with a 3-cycle transmitter model.
module tb_uart_tx_arbiter;

  localparam int FRAME = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic        force_busy = 1'b0;

  logic [1:0] a_ready, b_ready;
  logic       a_en, b_en, a_busy, b_busy, a_gid, b_gid, a_act, b_act;
  logic [7:0] a_data, b_data;
  int         a_cnt, b_cnt;

  int npass = 0, nchk = 0, cyc = 0;

  logic [7:0] a_tdata[16];
  logic       a_tgid[16];
  int         a_tcyc[16], a_rcyc[16], b_tcyc[16], b_rcyc[16];
  int         a_n, a_rn, b_n, b_rn;

  uart_tx_arbiter #(.NUM_REQ(2), .PAYLOAD_BITS(8), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(a_ready), .tx_en(a_en), .tx_data(a_data), .tx_busy(a_busy),
    .grant_id(a_gid), .active(a_act));

  uart_tx_arbiter #(.NUM_REQ(2), .PAYLOAD_BITS(8), .GAP_CYCLES(4)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_ready), .tx_en(b_en), .tx_data(b_data), .tx_busy(b_busy),
    .grant_id(b_gid), .active(b_act));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: busy rises the cycle after tx_en and lasts FRAME cycles.
  always @(posedge clk)
    if (!resetn) a_cnt <= 0; else if (a_en) a_cnt <= FRAME; else if (a_cnt != 0) a_cnt <= a_cnt - 1;
  always @(posedge clk)
    if (!resetn) b_cnt <= 0; else if (b_en) b_cnt <= FRAME; else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  assign a_busy = (a_cnt != 0) | force_busy;
  assign b_busy = (b_cnt != 0) | force_busy;

  always @(posedge clk) begin
    if (!resetn) begin
      a_n <= 0; a_rn <= 0; b_n <= 0; b_rn <= 0;
    end else begin
      if (a_en && a_n < 16) begin
        a_tdata[a_n] <= a_data; a_tgid[a_n] <= a_gid; a_tcyc[a_n] <= cyc; a_n <= a_n + 1;
      end
      if (|a_ready && a_rn < 16) begin a_rcyc[a_rn] <= cyc; a_rn <= a_rn + 1; end
      if (b_en && b_n < 16) begin b_tcyc[b_n] <= cyc; b_n <= b_n + 1; end
      if (|b_ready && b_rn < 16) begin b_rcyc[b_rn] <= cyc; b_rn <= b_rn + 1; end
    end
  end

  task automatic do_reset();
    resetn = 1'b0; req_valid = '0; force_busy = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_a(input int n, input int budget);
    int k = 0;
    while (a_n < n && k < budget) begin @(negedge clk); k++; end
    nchk++;
    if (a_n < n) $display("FAIL timeout_a: got %0d frames want %0d", a_n, n); else npass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 2'b01; req_data = 16'h0055;
    repeat (2) @(negedge clk);
    #1;
    nchk++; if (a_ready !== 2'b00) $display("FAIL rst_ready: got %b want 00", a_ready); else npass++;
    nchk++; if (a_en !== 1'b0) $display("FAIL rst_tx_en: got %b want 0", a_en); else npass++;
    nchk++; if (a_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", a_data); else npass++;
    nchk++; if (a_gid !== 1'b0) $display("FAIL rst_grant_id: got %b want 0", a_gid); else npass++;
    nchk++; if (a_act !== 1'b0 || b_act !== 1'b0) $display("FAIL rst_active: got %b%b want 00", a_act, b_act); else npass++;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_data = 16'h0055;
    #1;
    nchk++; if (a_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", a_ready); else npass++;
    @(negedge clk);
    nchk++; if (a_ready !== 2'b00) $display("FAIL single_ready_drop: got %b want 00", a_ready); else npass++;
    nchk++; if (a_en !== 1'b1) $display("FAIL single_tx_en: got %b want 1", a_en); else npass++;
    nchk++; if (a_data !== 8'h55) $display("FAIL single_tx_data: got %h want 55", a_data); else npass++;
    nchk++; if (a_act !== 1'b1) $display("FAIL single_active: got %b want 1", a_act); else npass++;
    req_data = 16'h0066;
    wait_a(2, 40);
    req_valid = '0;
    nchk++; if (a_rcyc[1] - a_rcyc[0] !== 6) $display("FAIL single_ready_spacing: got %0d want 6", a_rcyc[1] - a_rcyc[0]); else npass++;
    nchk++; if (a_tcyc[0] - a_rcyc[0] !== 1) $display("FAIL single_issue_latency: got %0d want 1", a_tcyc[0] - a_rcyc[0]); else npass++;
    nchk++; if (a_tdata[1] !== 8'h66) $display("FAIL single_second_byte: got %h want 66", a_tdata[1]); else npass++;
  endtask

  task automatic test_contention();
    logic [7:0] exp_d[4];
    logic       exp_g[4];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB1; exp_d[2] = 8'hA0; exp_d[3] = 8'hB1;
    exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;  exp_g[3] = 1'b1;
    do_reset();
    req_data = 16'hB1A0; req_valid = 2'b11;
    wait_a(4, 60);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      nchk++; if (a_tdata[i] !== exp_d[i]) $display("FAIL contend_data[%0d]: got %h want %h", i, a_tdata[i], exp_d[i]); else npass++;
      nchk++; if (a_tgid[i] !== exp_g[i]) $display("FAIL contend_gid[%0d]: got %b want %b", i, a_tgid[i], exp_g[i]); else npass++;
    end
  endtask

  task automatic test_gap();
    int k = 0;
    do_reset();
    req_data = 16'h005A; req_valid = 2'b01;
    while ((b_n < 2 || b_rn < 2) && k < 80) begin @(negedge clk); k++; end
    req_valid = '0;
    nchk++; if (b_n < 2 || b_rn < 2) $display("FAIL gap_timeout: got %0d frames want 2", b_n); else npass++;
    nchk++; if (b_rcyc[1] - b_rcyc[0] !== 10) $display("FAIL gap_ready_spacing: got %0d want 10", b_rcyc[1] - b_rcyc[0]); else npass++;
    nchk++; if (b_tcyc[1] - b_tcyc[0] !== 10) $display("FAIL gap_tx_spacing: got %0d want 10", b_tcyc[1] - b_tcyc[0]); else npass++;
    nchk++; if (b_tcyc[1] - b_rcyc[1] !== 1) $display("FAIL gap_issue_latency: got %0d want 1", b_tcyc[1] - b_rcyc[1]); else npass++;
    nchk++; if (a_tcyc[1] - a_tcyc[0] !== 6) $display("FAIL nogap_tx_spacing: got %0d want 6", a_tcyc[1] - a_tcyc[0]); else npass++;
  endtask

  task automatic test_busy_collision();
    do_reset();
    force_busy = 1'b1;
    req_data = 16'h0077; req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0; req_data = 16'h0088;
    for (int i = 0; i < 5; i++) begin
      #1;
      nchk++; if (a_en !== 1'b0) $display("FAIL busy_hold[%0d]: got tx_en %b want 0", i, a_en); else npass++;
      @(negedge clk);
    end
    force_busy = 1'b0;
    #1;
    nchk++; if (a_en !== 1'b1) $display("FAIL busy_release_en: got %b want 1", a_en); else npass++;
    nchk++; if (a_data !== 8'h77) $display("FAIL busy_release_data: got %h want 77", a_data); else npass++;
    repeat (10) @(negedge clk);
    nchk++; if (a_n !== 1) $display("FAIL busy_frame_count: got %0d want 1", a_n); else npass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = 16'h1200; req_valid = 2'b10;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    nchk++; if (a_act !== 1'b1) $display("FAIL mid_active_before: got %b want 1", a_act); else npass++;
    resetn = 1'b0; req_valid = 2'b10;
    @(negedge clk);
    #1;
    nchk++; if (a_en !== 1'b0) $display("FAIL mid_tx_en: got %b want 0", a_en); else npass++;
    nchk++; if (a_ready !== 2'b00) $display("FAIL mid_ready: got %b want 00", a_ready); else npass++;
    nchk++; if (a_gid !== 1'b0) $display("FAIL mid_grant_id: got %b want 0", a_gid); else npass++;
    nchk++; if (a_act !== 1'b0) $display("FAIL mid_active: got %b want 0", a_act); else npass++;
    resetn = 1'b1;
    wait_a(1, 20);
    req_valid = '0;
    nchk++; if (a_tdata[0] !== 8'h12) $display("FAIL mid_resume_data: got %h want 12", a_tdata[0]); else npass++;
    nchk++; if (a_tgid[0] !== 1'b1) $display("FAIL mid_resume_gid: got %b want 1", a_tgid[0]); else npass++;
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    int k = 0;
    logic ok = 1'b0;
    req_data[idx*8 +: 8] = b; req_valid[idx] = 1'b1;
    while (!ok && k < 60) begin
      #1;
      if (a_ready[idx]) ok = 1'b1;
      @(negedge clk);
      k++;
    end
    req_valid[idx] = 1'b0;
    nchk++; if (!ok) $display("FAIL send_timeout: req %0d byte %h not accepted", idx, b); else npass++;
  endtask

  task automatic test_tag();
    logic [7:0] exp_d[5];
    exp_d[0] = 8'h31; exp_d[1] = 8'h41; exp_d[2] = 8'h42; exp_d[3] = 8'h30; exp_d[4] = 8'h43;
    do_reset();
    send(1, 8'h41);
    send(1, 8'h42);
    send(0, 8'h43);
    wait_a(5, 60);
    for (int i = 0; i < 5; i++) begin
      nchk++; if (a_tdata[i] !== exp_d[i]) $display("FAIL tag_byte[%0d]: got %h want %h", i, a_tdata[i], exp_d[i]); else npass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
`ifdef UART_ARB_TAG_EN
    test_tag();
`else
    test_single();
    test_contention();
    test_gap();
    test_busy_collision();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
